digit_counter: RTL
==================

DIGIT_COUNTER -- requirements
Module: digit_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of cascaded digits (1..8).
REQ-002 SHALL have parameter BASE, default 10, modulus of each digit (2..2^W).
REQ-003 SHALL have parameter W, default 4, bits per digit.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  count enable; one step per cycle while high.
REQ-007 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port clr  input  1  synchronous clear of count and ovf.
REQ-009 SHALL have port load  input  1  parallel load strobe (only with DIGIT_CNT_LOAD_EN).
REQ-010 SHALL have port load_val  input  DIGITS*W  parallel load value, digit 0 in LSBs (only with DIGIT_CNT_LOAD_EN).
REQ-011 SHALL have port cnt  output  DIGITS*W  registered count, digit 0 (least significant) in bits [W-1:0].
REQ-012 SHALL have port tc  output  1  combinational terminal-count/carry-out for cascading.
REQ-013 SHALL have port ovf  output  1  registered sticky wrap flag.

Function
REQ-014 Each digit SHALL hold a value in 0..BASE-1 at all times after reset.
REQ-015 Per-cycle priority SHALL be: rst > clr > load > en; lower-priority actions ignored that cycle.
REQ-016 en=1, up=1: digit 0 SHALL increment; digit k SHALL increment only when digits 0..k-1 all equal BASE-1; a digit at BASE-1 that steps SHALL become 0.
REQ-017 en=1, up=0: digit 0 SHALL decrement; digit k SHALL decrement only when digits 0..k-1 all equal 0; a digit at 0 that steps SHALL become BASE-1.
REQ-018 Full-range wrap: up from all digits BASE-1 SHALL yield all 0; down from all 0 SHALL yield all BASE-1.
REQ-019 en=0 (and no clr/load/rst) SHALL hold cnt and ovf unchanged; up changes alone SHALL not alter state.
REQ-020 tc SHALL be 1 iff en=1 and (up=1 and all digits = BASE-1, or up=0 and all digits = 0); it SHALL be 0 during cycles where rst, clr or load is 1.
REQ-021 ovf SHALL set on the clock edge where a full-range wrap (tc=1) occurs and stay 1 until rst or clr.
REQ-022 Count latency SHALL be one cycle: cnt reflects the step on the edge where en was sampled high.
REQ-023 clr=1 SHALL set cnt to 0 and ovf to 0 on the next edge regardless of en/load.
REQ-024 Direction reversal between consecutive enabled cycles SHALL take effect immediately with no dead cycle.

Reset
REQ-025 rst=1 sampled on a rising edge SHALL set cnt=0, ovf=0; tc SHALL be 0 while rst=1.
REQ-026 rst asserted mid-count SHALL override any simultaneous en, clr or load.
REQ-027 First count step SHALL occur on the first edge after rst deasserts with en=1.

Configuration
REQ-028 Macro DIGIT_CNT_LOAD_EN defined: load and load_val ports SHALL exist; load=1 SHALL set cnt to load_val next edge, with any digit >= BASE replaced by BASE-1, and ovf unchanged.
REQ-029 Macro DIGIT_CNT_LOAD_EN undefined: load and load_val ports SHALL be absent and behaviour SHALL equal the defined build with load tied to 0.

Verification
REQ-030 Defaults, rst 1 cycle then en=1 up=1 for 10 cycles -> cnt steps 0001..0009 then 0010 (digit0=0, digit1=1).
REQ-031 cnt=9999, en=1 up=1 -> tc=1 that cycle; next cnt=0000, ovf=1; ovf holds with en=0 until clr=1 -> ovf=0, cnt=0000.
REQ-032 From reset, en=1 up=0 one cycle -> tc=1, next cnt=9999, ovf=1; further down step -> 9998, tc=0.
REQ-033 BASE=6, DIGITS=2, count up 36 steps from 00 -> sequence 00..05,10..55, wraps to 00 on step 36 with tc=1 on cycle 36.
REQ-034 DIGIT_CNT_LOAD_EN defined: load=1 load_val=0x12C4 with en=1 -> next cnt=0x1294 (digit1 C clamped to 9), no step; same cycle clr=1 -> cnt=0000 instead.
REQ-035 cnt=0523, en=1 with rst=1 and clr=1 same cycle -> cnt=0000, ovf=0, tc=0; en=1 next cycle -> 0001.

Source files
------------

// File: rtl/digit_counter.sv
// digit_counter: cascaded modulo-BASE up/down digit counter with a terminal-count
// output and a sticky wrap flag.
// Optional parallel load: define DIGIT_CNT_LOAD_EN to add the load/load_val ports.
// Without the macro the counter behaves as if load were tied low.
module digit_counter #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BASE   = 10,
  parameter int unsigned W      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                clr,
`ifdef DIGIT_CNT_LOAD_EN
  input  logic                load,
  input  logic [DIGITS*W-1:0] load_val,
`endif
  output logic [DIGITS*W-1:0] cnt,
  output logic                tc,
  output logic                ovf
);

  localparam logic [W-1:0] MaxDig = W'(BASE - 1);

  logic [DIGITS*W-1:0] cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [DIGITS-1:0]   step;       // digit k moves this cycle (when enabled)
  logic                all_max;
  logic                all_min;
  logic                wrap;       // full-range wrap in the current direction
  logic                load_eff;
  logic [DIGITS*W-1:0] load_clamped;

`ifdef DIGIT_CNT_LOAD_EN
  assign load_eff = load;

  // Clamp each loaded digit into 0..BASE-1.
  always_comb begin
    load_clamped = load_val;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (load_val[k*W +: W] > MaxDig) begin
        load_clamped[k*W +: W] = MaxDig;
      end
    end
  end
`else
  assign load_eff     = 1'b0;
  assign load_clamped = '0;
`endif

  // Carry/borrow chain: a digit moves when every lower digit is at its rollover value.
  always_comb begin
    logic run_max;
    logic run_min;
    run_max = 1'b1;
    run_min = 1'b1;
    step    = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      step[k] = up ? run_max : run_min;
      run_max = run_max & (cnt_q[k*W +: W] == MaxDig);
      run_min = run_min & (cnt_q[k*W +: W] == '0);
    end
    all_max = run_max;
    all_min = run_min;
  end

  assign wrap = up ? all_max : all_min;

  // Next count/flag, priority clr > load > en (rst handled in the register).
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load_eff) begin
      cnt_d = load_clamped;
    end else if (en) begin
      for (int k = 0; k < int'(DIGITS); k++) begin
        if (step[k]) begin
          if (up) begin
            cnt_d[k*W +: W] = (cnt_q[k*W +: W] == MaxDig) ? '0 : cnt_q[k*W +: W] + W'(1);
          end else begin
            cnt_d[k*W +: W] = (cnt_q[k*W +: W] == '0) ? MaxDig : cnt_q[k*W +: W] - W'(1);
          end
        end
      end
      ovf_d = ovf_q | wrap;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;
  // Terminal count only on a cycle that will actually step.
  assign tc  = en & ~rst & ~clr & ~load_eff & wrap;

endmodule
